// File: rtl/zeroriscy_clock_gate_ctrl.sv
// Core clock-gate controller: idle hysteresis before gating, timed wake with an
// acknowledge pulse, and a saturating count of gated cycles.
module zeroriscy_clock_gate_ctrl #(
    parameter int unsigned IDLE_CYCLES = 8,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              busy_i,
    input  logic              sleep_req_i,
    input  logic              wake_req_i,
    input  logic              test_en_i,
    input  logic              clr_cnt_i,
    output logic              clock_en_o,
    output logic              sleeping_o,
    output logic              wake_ack_o,
    output logic [PERF_W-1:0] sleep_cnt_o
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IDLE_WAIT = 2'd1,
        SLEEP     = 2'd2,
        WAKE      = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                clock_en_q;
    logic                sleeping_q;
    logic                wake_ack_q;
    logic [PERF_W-1:0]   sleep_cnt_q;
    logic [PERF_W-1:0]   sleep_cnt_d;

    // Outputs are registered alongside the state so they track it cycle-exactly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            clock_en_q <= 1'b1;
            sleeping_q <= 1'b0;
            wake_ack_q <= 1'b0;
        end else begin
            wake_ack_q <= 1'b0;
            if (test_en_i) begin
                state_q    <= RUN;
                cnt_q      <= '0;
                clock_en_q <= 1'b1;
                sleeping_q <= 1'b0;
                wake_ack_q <= (state_q == SLEEP) || (state_q == WAKE);
            end else begin
                case (state_q)
                    RUN: begin
                        clock_en_q <= 1'b1;
                        sleeping_q <= 1'b0;
                        if (sleep_req_i && !busy_i && !wake_req_i) begin
                            state_q <= IDLE_WAIT;
                            cnt_q   <= IDLE_LOAD;
                        end
                    end
                    IDLE_WAIT: begin
                        if (busy_i || wake_req_i || !sleep_req_i) begin
                            state_q <= RUN;
                            cnt_q   <= '0;
                        end else if (cnt_q == '0) begin
                            state_q    <= SLEEP;
                            clock_en_q <= 1'b0;
                            sleeping_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    SLEEP: begin
                        if (wake_req_i) begin
                            state_q    <= WAKE;
                            cnt_q      <= WAKE_LOAD;
                            clock_en_q <= 1'b1;
                            sleeping_q <= 1'b0;
                        end
                    end
                    WAKE: begin
                        if (cnt_q == '0) begin
                            state_q    <= RUN;
                            wake_ack_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q    <= RUN;
                        cnt_q      <= '0;
                        clock_en_q <= 1'b1;
                        sleeping_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating sleep-cycle counter; a clear takes precedence over counting.
    always_comb begin
        sleep_cnt_d = sleep_cnt_q;
        if (clr_cnt_i) begin
            sleep_cnt_d = '0;
        end else if ((state_q == SLEEP) && (sleep_cnt_q != '1)) begin
            sleep_cnt_d = sleep_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sleep_cnt_q <= '0;
        end else begin
            sleep_cnt_q <= sleep_cnt_d;
        end
    end

    assign clock_en_o  = clock_en_q;
    assign sleeping_o  = sleeping_q;
    assign wake_ack_o  = wake_ack_q;
    assign sleep_cnt_o = sleep_cnt_q;

endmodule

// File: tb/tb_zeroriscy_clock_gate_ctrl.sv
// Directed table-driven bench for zeroriscy_clock_gate_ctrl, with a second
// 4-bit-counter instance sharing the inputs to exercise saturation.
module tb_zeroriscy_clock_gate_ctrl;

    logic        clk;
    logic        rst_n;
    logic        busy, sleep_req, wake_req, test_en, clr_cnt;
    logic        en, sl, ack;
    logic [15:0] cnt;
    logic        en_s, sl_s, ack_s;
    logic [3:0]  cnt_s;

    int errors = 0;
    int checks = 0;

    zeroriscy_clock_gate_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .busy_i      (busy),
        .sleep_req_i (sleep_req),
        .wake_req_i  (wake_req),
        .test_en_i   (test_en),
        .clr_cnt_i   (clr_cnt),
        .clock_en_o  (en),
        .sleeping_o  (sl),
        .wake_ack_o  (ack),
        .sleep_cnt_o (cnt)
    );

    zeroriscy_clock_gate_ctrl #(.PERF_W(4)) dut_s (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .busy_i      (busy),
        .sleep_req_i (sleep_req),
        .wake_req_i  (wake_req),
        .test_en_i   (test_en),
        .clr_cnt_i   (clr_cnt),
        .clock_en_o  (en_s),
        .sleeping_o  (sl_s),
        .wake_ack_o  (ack_s),
        .sleep_cnt_o (cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic b, s, w, t, c;
        int   n;
        logic en, sl, ack;
        int   cnt, cnt_s;   // -1: not checked for this record
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic b, s, w, t, c, input int n,
                       input logic e, l, a, input int ct, input int cs);
        vec_t v;
        v.b = b; v.s = s; v.w = w; v.t = t; v.c = c; v.n = n;
        v.en = e; v.sl = l; v.ack = a; v.cnt = ct; v.cnt_s = cs;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic b, s, w, t, c);
        busy = b; sleep_req = s; wake_req = w; test_en = t; clr_cnt = c;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;

        //      b s w t c   n  en sl ack cnt cnt_s
        add(0,0,0,0,0, 50, 1,0,0,  0,  0);   // idle, clock held on
        add(0,1,1,0,0,  3, 1,0,0, -1, -1);   // sleep with wake pending: stay RUN
        add(1,1,0,0,0,  3, 1,0,0, -1, -1);   // busy blocks sleep
        add(0,1,0,0,0,  8, 1,0,0,  0,  0);   // IDLE_WAIT countdown
        add(0,1,0,0,0,  5, 0,1,0, -1, -1);   // gated
        add(1,1,0,0,0,  6, 0,1,0, 10, 10);   // busy ignored while asleep
        add(0,0,1,0,0,  1, 1,0,0, 11, 11);   // wake: clock back on
        add(1,1,1,0,0,  1, 1,0,0, 11, 11);   // inputs ignored in WAKE
        add(0,0,0,0,0,  1, 1,0,1, -1, -1);   // ack pulse
        add(0,0,0,0,0,  3, 1,0,0, 11, 11);
        add(0,1,0,0,0,  3, 1,0,0, -1, -1);   // wake aborts IDLE_WAIT
        add(0,1,1,0,0,  1, 1,0,0, -1, -1);
        add(0,1,0,0,0,  5, 1,0,0, -1, -1);   // busy aborts at 5th IDLE_WAIT cycle
        add(1,1,0,0,0,  1, 1,0,0, -1, -1);
        add(0,1,0,0,0,  8, 1,0,0, -1, -1);   // full fresh countdown
        add(0,1,0,0,0,  2, 0,1,0, 12, 12);
        add(0,1,0,1,0,  1, 1,0,1, 13, 13);   // test_en from SLEEP: ack
        add(0,0,0,0,0,  1, 1,0,0, -1, -1);
        add(0,1,0,1,0,  3, 1,0,0, -1, -1);   // test_en in RUN: no ack
        add(0,1,0,0,0,  3, 1,0,0, -1, -1);
        add(0,1,0,1,0,  1, 1,0,0, -1, -1);   // test_en from IDLE_WAIT: no ack
        add(0,1,0,0,0,  8, 1,0,0, -1, -1);
        add(0,1,0,0,0,  1, 0,1,0, -1, -1);
        add(0,0,1,0,0,  1, 1,0,0, -1, -1);
        add(0,0,0,1,0,  1, 1,0,1, -1, -1);   // test_en from WAKE: ack
        add(0,0,0,0,0,  1, 1,0,0, 14, 14);
        add(0,0,0,0,1,  1, 1,0,0,  0,  0);   // clear in RUN
        add(0,1,0,0,0,  8, 1,0,0,  0,  0);
        add(0,1,0,0,0, 20, 0,1,0, 19, 15);   // 4-bit counter saturates
        add(0,1,0,0,1,  1, 0,1,0,  0,  0);   // clear beats increment
        add(0,1,0,0,0,  1, 0,1,0,  1,  1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset clock_en", en, 1);
        chk("reset sleeping", sl, 0);
        chk("reset wake_ack", ack, 0);
        chk("reset sleep_cnt", cnt, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                drive(tbl[i].b, tbl[i].s, tbl[i].w, tbl[i].t, tbl[i].c);
                @(posedge clk);
                #1;
                chk($sformatf("rec%0d/%0d clock_en", i, k), en, tbl[i].en);
                chk($sformatf("rec%0d/%0d sleeping", i, k), sl, tbl[i].sl);
                chk($sformatf("rec%0d/%0d wake_ack", i, k), ack, tbl[i].ack);
                if (k == tbl[i].n - 1 && tbl[i].cnt >= 0) begin
                    chk($sformatf("rec%0d sleep_cnt", i), cnt, tbl[i].cnt);
                    chk($sformatf("rec%0d sleep_cnt_4b", i), cnt_s, tbl[i].cnt_s);
                end
            end
        end

        // Wake from SLEEP, then reset asynchronously in the middle of WAKE.
        drive(0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("mid-wake clock_en", en, 1);
        chk("mid-wake sleeping", sl, 0);
        drive(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst clock_en", en, 1);
        chk("async rst sleeping", sl, 0);
        chk("async rst wake_ack", ack, 0);
        chk("async rst sleep_cnt", cnt, 0);
        chk("async rst sleep_cnt_4b", cnt_s, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post rst %0d wake_ack", k), ack, 0);
            chk($sformatf("post rst %0d clock_en", k), en, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
